// File: rtl/gsim_result_buffer.sv
// GSIM result buffer: captures a DEPTH-word Q16.16 burst, rounds/saturates each word to OUT_W bits,
// and replays the frame over valid/ready while tracking a raw-frame checksum and a sticky drop flag.
module gsim_result_buffer #(
  parameter int DEPTH = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      x_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             frame_done,
  output logic [31:0]      frame_sum,
  output logic             overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic signed [32:0] RND  = 33'sd1 <<< (SHIFT - 1);
  localparam logic signed [32:0] MAXV = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] MINV = -(33'sd1 <<< (OUT_W - 1));

  typedef enum logic [0:0] {COLLECT = 1'b0, DRAIN = 1'b1} state_t;

  // Round half toward +inf, then clamp to the signed OUT_W range.
  function automatic logic [OUT_W-1:0] convert_word(input logic [31:0] x);
    logic signed [32:0] t;
    logic [OUT_W-1:0]   r;
    t = $signed({x[31], x}) + RND;
    t = t >>> SHIFT;
    if (t > MAXV) begin
      r = MAXV[OUT_W-1:0];
    end else if (t < MINV) begin
      r = MINV[OUT_W-1:0];
    end else begin
      r = t[OUT_W-1:0];
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [31:0]      frame_sum_q, frame_sum_d;
  logic [31:0]      acc_q, acc_d;
  logic             overflow_q, overflow_d;
  logic [OUT_W-1:0] mem_q [DEPTH];
  logic             mem_we_s;
  logic [OUT_W-1:0] conv_s;
  logic [PW-1:0]    rd_next_s;
  logic             handshake_s;

  assign conv_s      = convert_word(x_in);
  assign handshake_s = out_valid_q & out_ready;
  assign rd_next_s   = (rd_ptr_q == PTR_LAST) ? PTR_ZERO : (rd_ptr_q + PTR_ONE);

  // Next-state and datapath decisions for capture and replay.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    frame_sum_d = frame_sum_q;
    acc_d       = acc_q;
    overflow_d  = overflow_q;
    mem_we_s    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          mem_we_s = 1'b1;
          if (wr_ptr_q == PTR_LAST) begin
            wr_ptr_d    = PTR_ZERO;
            acc_d       = 32'd0;
            frame_sum_d = acc_q + x_in;
            state_d     = DRAIN;
            out_valid_d = 1'b1;
            // Word 0 is already in memory unless the frame is a single word.
            out_data_d  = (wr_ptr_q == PTR_ZERO) ? conv_s : mem_q[0];
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            acc_d    = acc_q + x_in;
          end
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      DRAIN: begin
        if (in_valid) begin
          overflow_d = 1'b1;
        end else begin
          overflow_d = overflow_q;
        end
        if (handshake_s) begin
          rd_ptr_d = rd_next_s;
          if (rd_ptr_q == PTR_LAST) begin
            out_valid_d = 1'b0;
            state_d     = COLLECT;
          end else begin
            out_data_d = mem_q[rd_next_s];
          end
        end else begin
          rd_ptr_d = rd_ptr_q;
        end
      end
      default: begin
        state_d     = COLLECT;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= COLLECT;
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      out_valid_q <= 1'b0;
      out_data_q  <= {OUT_W{1'b0}};
      frame_sum_q <= 32'd0;
      acc_q       <= 32'd0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      frame_sum_q <= frame_sum_d;
      acc_q       <= acc_d;
      overflow_q  <= overflow_d;
    end
  end

  // Frame storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= conv_s;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_sum  = frame_sum_q;
  assign overflow   = overflow_q;
  assign frame_done = handshake_s & (state_q == DRAIN) & (rd_ptr_q == PTR_LAST);

endmodule

// File: tb/tb_gsim_result_buffer.sv
// Randomized bench for gsim_result_buffer against a queue-based frame model.
module tb_gsim_result_buffer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] x_in;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        frame_done;
  logic [31:0] frame_sum;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  bit          m_drain;
  logic [15:0] m_col[$];
  logic [15:0] m_out[$];
  logic [31:0] m_acc;
  logic [31:0] m_sum;
  bit          m_ovf;

  gsim_result_buffer #(.DEPTH(16), .OUT_W(16), .SHIFT(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .frame_done(frame_done),
    .frame_sum(frame_sum), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Q16.16 -> Q8.8 by plain integer arithmetic: floor((x + 0.5 LSB) / 256), then clamp.
  function automatic logic [15:0] ref_conv(input logic [31:0] x);
    longint v;
    longint q;
    v = longint'($signed(x)) + 64'sd128;
    if (v >= 0) q = v / 256;
    else q = -((-v + 255) / 256);
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  task automatic model_reset();
    m_drain = 1'b0;
    m_col.delete();
    m_out.delete();
    m_acc = 32'd0;
    m_sum = 32'd0;
    m_ovf = 1'b0;
  endtask

  // One clock: apply inputs, check outputs against the model, then advance the model at the edge.
  task automatic drive(input bit iv, input logic [31:0] x, input bit rdy);
    @(negedge clk);
    in_valid = iv;
    x_in = x;
    out_ready = rdy;
    #1;
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_drain});
    if (m_drain) check_eq("out_data", {16'd0, out_data}, {16'd0, m_out[0]});
    check_eq("frame_done", {31'd0, frame_done}, {31'd0, (m_drain && rdy && m_out.size() == 1)});
    check_eq("frame_sum", frame_sum, m_sum);
    check_eq("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    @(posedge clk);
    if (m_drain) begin
      if (iv) m_ovf = 1'b1;
      if (rdy) begin
        void'(m_out.pop_front());
        if (m_out.size() == 0) m_drain = 1'b0;
      end
    end else if (iv) begin
      m_col.push_back(ref_conv(x));
      m_acc = m_acc + x;
      if (m_col.size() == 16) begin
        m_sum = m_acc;
        m_acc = 32'd0;
        m_out = m_col;
        m_col.delete();
        m_drain = 1'b1;
      end
    end
  endtask

  task automatic drain(input int stall_pct);
    int n;
    n = 0;
    while (m_drain && n < 400) begin
      drive(1'b0, 32'd0, ($urandom_range(99) >= stall_pct));
      n++;
    end
    if (m_drain) check_eq("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #2;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", {16'd0, out_data}, 32'd0);
    check_eq("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check_eq("rst_frame_sum", frame_sum, 32'd0);
    check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [31:0] w;

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    x_in = 32'd0;
    out_ready = 1'b0;
    model_reset();
    apply_reset();

    // Basic frame of 1.5
    for (int i = 0; i < 16; i++) drive(1'b1, 32'h0001_8000, 1'b1);
    #1;
    check_eq("t1_sum", frame_sum, 32'h0018_0000);
    check_eq("t1_data", {16'd0, out_data}, 32'h0000_0180);
    drain(0);

    // Rounding boundaries, then random fill
    drive(1'b1, 32'h0000_0080, 1'b1);
    drive(1'b1, 32'h0000_007F, 1'b1);
    drive(1'b1, 32'hFFFF_FF80, 1'b1);
    drive(1'b1, 32'hFFFF_FF7F, 1'b1);
    for (int i = 4; i < 16; i++) drive(1'b1, $urandom, 1'b1);
    #1;
    check_eq("t2_first", {16'd0, out_data}, 32'h0000_0001);
    drain(0);

    // Saturation words mixed with ordinary ones
    for (int i = 0; i < 16; i++) begin
      if (i == 3) w = 32'h0100_0000;
      else if (i == 9) w = 32'h8000_0000;
      else w = $urandom_range(32'h0010_0000) - 32'h0008_0000;
      drive(1'b1, w, 1'b1);
    end
    drain(0);

    // Backpressure with heavy random stalls
    for (int i = 0; i < 16; i++) drive(1'b1, $urandom, 1'b0);
    drain(60);

    // Gapped input burst: 8 words, 5 idle cycles, 8 words
    for (int i = 0; i < 8; i++) drive(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, $urandom, 1'b0);
    drain(30);

    // Words arriving during drain are dropped and flagged
    for (int i = 0; i < 16; i++) drive(1'b1, $urandom, 1'b0);
    drive(1'b1, 32'h1234_5678, 1'b0);
    drive(1'b1, 32'h0BAD_0BAD, 1'b1);
    drain(20);
    #1;
    check_eq("t6_ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset in the middle of a drain, then a clean frame
    for (int i = 0; i < 16; i++) drive(1'b1, $urandom, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'd0, 1'b1);
    apply_reset();
    for (int i = 0; i < 16; i++) drive(1'b1, $urandom, 1'b1);
    drain(0);

    // Random frames with random input gaps and stalls
    for (int f = 0; f < 6; f++) begin
      int guard;
      guard = 0;
      while (!m_drain && guard < 200) begin
        drive(($urandom_range(3) != 0), $urandom, 1'b0);
        guard++;
      end
      drain($urandom_range(50));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
